// File: rtl/rr_sel_gen.sv
// Round-robin select generator for a 4:1 mux: valid/ready handshake on sel, accepted-grant counter.
// Optional RR_SEL_LOCK_EN adds a lock input that re-grants the same input on accept.
module rr_sel_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic             ready,
`ifdef RR_SEL_LOCK_EN
  input  logic             lock,
`endif
  output logic [1:0]       sel,
  output logic [3:0]       gnt,
  output logic             valid,
  output logic [CNT_W-1:0] grant_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             hold;

  // First set request bit searching upward from p, wrapping mod 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign accept = valid_q && ready;
`ifdef RR_SEL_LOCK_EN
  assign hold = lock;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (|req) begin
          sel_d   = rr_pick(req, ptr_q);
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        valid_d = 1'b1;
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!hold) begin
            ptr_d = sel_q + 2'd1;
            if (|req) begin
              sel_d = rr_pick(req, sel_q + 2'd1);
            end else begin
              valid_d = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // gnt depends only on registered sel/valid, never on req or ready.
  assign sel       = sel_q;
  assign valid     = valid_q;
  assign gnt       = valid_q ? (4'b0001 << sel_q) : 4'b0000;
  assign grant_cnt = cnt_q;

endmodule
